spike_rate_window: RTL and testbench

Rate-decoding stage that sits directly downstream of the neuron output layer. It samples the registered 1-bit fire signal once per clock over a fixed window and counts the fires. It then presents the count and a majority decision through a valid/ready output register. The block turns the per-cycle neuron decision into a stable, rate-coded classification that a slow consumer (host, pin sampler) can read.

---
 rtl/neuron_pkg.sv | 12 +
 rtl/spike_result_reg.sv | 44 ++++
 rtl/spike_rate_window.sv | 153 +++++++++++++++
 tb/tb_spike_rate_window.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and default constants for the neuron output-layer decoding stages.
package neuron_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } spike_win_state_t;

  localparam int SPIKE_WINDOW_DEF = 16;
  localparam int SPIKE_THRESH_DEF = 8;

endpackage

// File: rtl/spike_result_reg.sv
// Valid/ready holding register for a window result, with a sticky overrun flag
// that records results dropped while an unread result was still held.
module spike_result_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic              overrun
);

  // Load/accept/overrun bookkeeping; a load in the same cycle as an accept wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      q       <= {DATA_W{1'b0}};
      overrun <= 1'b0;
    end else begin
      if (load) begin
        if (!valid || ready) begin
          q     <= data;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end else begin
        valid <= valid;
      end
      if (clear) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun | (load & valid & ~ready);
      end
    end
  end

endmodule

// File: rtl/spike_rate_window.sv
// Windowed spike counter with majority decision behind a valid/ready result register.
// Optional first-fire index capture is enabled by defining SPIKE_RATE_FIRST_EN.
module spike_rate_window
  import neuron_pkg::*;
#(
  parameter  int WINDOW = SPIKE_WINDOW_DEF,
  parameter  int THRESH = SPIKE_THRESH_DEF,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             clear_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             fire_o,
  output logic [CNT_W-1:0] first_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] WIN_VAL  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] THR_VAL  = CNT_W'(THRESH);

`ifdef SPIKE_RATE_FIRST_EN
  localparam int DATA_W = 2 * CNT_W + 1;
`else
  localparam int DATA_W = CNT_W + 1;
`endif

  spike_win_state_t state_r, state_s;
  logic [CNT_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] idx_r, idx_s;
  logic [CNT_W-1:0] result_s;
  logic             win_end_s;
  logic             fire_s;
  logic [DATA_W-1:0] data_s;
  logic [DATA_W-1:0] data_q;

  assign result_s = acc_r + {{(CNT_W-1){1'b0}}, spike_i};
  assign fire_s   = (result_s >= THR_VAL);

  // Next-state, accumulator and sample-index update; clear_i overrides everything.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    idx_s     = idx_r;
    win_end_s = 1'b0;
    if (clear_i) begin
      state_s = IDLE;
      acc_s   = CNT_ZERO;
      idx_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_s = COUNT;
          end else begin
            state_s = IDLE;
          end
        end
        COUNT: begin
          if (idx_r == WIN_LAST) begin
            win_end_s = 1'b1;
            acc_s     = CNT_ZERO;
            idx_s     = CNT_ZERO;
            state_s   = cont_i ? COUNT : IDLE;
          end else begin
            acc_s = result_s;
            idx_s = idx_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          acc_s   = CNT_ZERO;
          idx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Window state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= CNT_ZERO;
      idx_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      idx_r   <= idx_s;
    end
  end

`ifdef SPIKE_RATE_FIRST_EN
  // first_r holds WIN_VAL until the first fire of the window is seen.
  logic [CNT_W-1:0] first_r, first_s, first_res_s;

  assign first_res_s = ((first_r == WIN_VAL) && spike_i) ? idx_r : first_r;

  // First-fire index tracking, rearmed at every window boundary or abort.
  always_comb begin
    first_s = first_r;
    if (clear_i || win_end_s) begin
      first_s = WIN_VAL;
    end else if (state_r == COUNT) begin
      first_s = first_res_s;
    end else begin
      first_s = first_r;
    end
  end

  // First-fire index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r <= WIN_VAL;
    end else begin
      first_r <= first_s;
    end
  end

  assign data_s  = {first_res_s, fire_s, result_s};
  assign first_o = data_q[2*CNT_W:CNT_W+1];
`else
  assign data_s  = {fire_s, result_s};
  assign first_o = CNT_ZERO;
`endif

  spike_result_reg #(
    .DATA_W (DATA_W)
  ) u_result (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_i),
    .load    (win_end_s),
    .data    (data_s),
    .ready   (ready_i),
    .valid   (valid_o),
    .q       (data_q),
    .overrun (overrun_o)
  );

  assign count_o = data_q[CNT_W-1:0];
  assign fire_o  = data_q[CNT_W];
  assign busy_o  = (state_r == COUNT);

endmodule

// File: tb/tb_spike_rate_window.sv
// Self-checking bench: directed test-plan scenarios followed by random stimulus,
// every cycle compared against a sample-list reference model.
module tb_spike_rate_window;
  import neuron_pkg::*;

  localparam int WIN = SPIKE_WINDOW_DEF;
  localparam int THR = SPIKE_THRESH_DEF;
  localparam int CW  = $clog2(WIN + 1);

  logic          clk = 1'b0;
  logic          rst, spike, start, cont, clear, ready;
  logic          valid, fire, busy, overrun;
  logic [CW-1:0] count, first;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit m_busy, m_valid, m_fire, m_over;
  int m_count, m_first;
  bit m_samp[$];

  spike_rate_window #(.WINDOW(WIN), .THRESH(THR)) dut (
    .clk       (clk),
    .rst       (rst),
    .spike_i   (spike),
    .start_i   (start),
    .cont_i    (cont),
    .clear_i   (clear),
    .ready_i   (ready),
    .valid_o   (valid),
    .count_o   (count),
    .fire_o    (fire),
    .first_o   (first),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, st, ct, cl, rd, sp);
    bit ld;
    int sum, fidx;
    ld = 1'b0;
    sum = 0;
    fidx = WIN;
    if (r) begin
      m_busy = 0; m_valid = 0; m_fire = 0; m_over = 0;
      m_count = 0; m_first = 0;
      m_samp.delete();
    end else begin
      if (cl) begin
        m_busy = 0;
        m_over = 0;
        m_samp.delete();
      end else if (m_busy) begin
        m_samp.push_back(sp);
        if (m_samp.size() == WIN) begin
          for (int i = WIN - 1; i >= 0; i--) begin
            sum += int'(m_samp[i]);
            if (m_samp[i]) fidx = i;
          end
          ld = 1'b1;
          m_busy = ct;
          m_samp.delete();
        end
      end else if (st) begin
        m_busy = 1;
      end
      if (ld) begin
        if (!m_valid || rd) begin
          m_count = sum;
          m_fire  = (sum >= THR);
          m_first = fidx;
          m_valid = 1;
        end else begin
          m_over = 1;
        end
      end else if (m_valid && rd) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step(input bit r, st, ct, cl, rd, sp);
    rst = r; start = st; cont = ct; clear = cl; ready = rd; spike = sp;
    @(posedge clk);
    model_edge(r, st, ct, cl, rd, sp);
    #1;
    chk("valid",   32'(valid),   32'(m_valid));
    chk("count",   32'(count),   32'(m_count));
    chk("fire",    32'(fire),    32'(m_fire));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("overrun", 32'(overrun), 32'(m_over));
`ifdef SPIKE_RATE_FIRST_EN
    chk("first",   32'(first),   32'(m_first));
`else
    chk("first",   32'(first),   32'd0);
`endif
  endtask

  // One full window of samples, nf fires placed at the tail of the window.
  task automatic window(input int nf, input bit ct, input bit rd, input bit rd_last);
    for (int i = 0; i < WIN; i++) begin
      step(1'b0, 1'b0, ct, 1'b0, (i == WIN - 1) ? rd_last : rd, (i >= WIN - nf));
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);

    // 10 of 16 fires, single window
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    window(10, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_count", 32'(count), 32'd10);
    chk("t1_fire",  32'(fire),  32'd1);
    chk("t1_busy",  32'(busy),  32'd0);

    // silent window
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    window(0, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_fire",  32'(fire),  32'd0);
`ifdef SPIKE_RATE_FIRST_EN
    chk("t2_first", 32'(first), 32'(WIN));
`endif

    // back-to-back continuous windows 8, 7, 16 fires
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    window(8, 1'b1, 1'b1, 1'b1);
    chk("t3_fire_a", 32'(fire), 32'd1);
    window(7, 1'b1, 1'b1, 1'b1);
    chk("t3_fire_b", 32'(fire), 32'd0);
    window(16, 1'b0, 1'b1, 1'b1);
    chk("t3_fire_c", 32'(fire), 32'd1);
    chk("t3_count_c", 32'(count), 32'd16);
    chk("t3_over", 32'(overrun), 32'd0);

    // consumer stalls for two windows
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    window(5, 1'b1, 1'b0, 1'b0);
    window(12, 1'b0, 1'b0, 1'b0);
    chk("t4_count", 32'(count), 32'd5);
    chk("t4_over",  32'(overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_over_clr", 32'(overrun), 32'd0);
    chk("t4_valid",    32'(valid),   32'd1);

    // ready asserted exactly on window end while valid
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    window(9, 1'b0, 1'b0, 1'b1);
    chk("t5_valid", 32'(valid), 32'd1);
    chk("t5_count", 32'(count), 32'd9);
    chk("t5_over",  32'(overrun), 32'd0);

    // clear at sample 5, then rst at sample 5
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_busy",  32'(busy),  32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_busy",  32'(busy),  32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(499) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(1) == 0),
           ($urandom_range(59) == 0),
           ($urandom_range(2) == 0),
           ($urandom_range(1) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
